fade_channels: RTL and testbench

FADE_CHANNELS -- requirements
Module: fade_channels

---
 rtl/fade_pkg.sv | 33 +++
 rtl/fade_tick.sv | 28 ++
 rtl/fade_channels.sv | 157 +++++++++++++++
 tb/tb_fade_channels.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fade_pkg.sv
// Shared types and helpers for the fade_channels phase sequencer.
// The optional PWM output stage is enabled by FADE_CHANNELS_PWM_OUT_EN (see fade_channels.sv).
package fade_pkg;

    typedef enum logic [2:0] {
        ST_INC = 3'd0,
        ST_HI  = 3'd1,
        ST_HI2 = 3'd2,
        ST_DEC = 3'd3,
        ST_LO  = 3'd4,
        ST_LO2 = 3'd5
    } state_t;

    function automatic state_t next_state(input state_t s);
        case (s)
            ST_INC:  return ST_HI;
            ST_HI:   return ST_HI2;
            ST_HI2:  return ST_DEC;
            ST_DEC:  return ST_LO;
            ST_LO:   return ST_LO2;
            default: return ST_INC;
        endcase
    endfunction

    function automatic int unsigned init_value(input state_t s, input int unsigned max_val);
        return (s == ST_HI || s == ST_HI2 || s == ST_DEC) ? max_val : 0;
    endfunction

    function automatic state_t reset_state(input int k, input int ofs);
        return state_t'(3'((k * ofs) % 6));
    endfunction

endpackage

// File: rtl/fade_tick.sv
// Step tick generator: one-cycle tick every TICK_INTERVAL enabled clock cycles.
module fade_tick #(
    parameter int TICK_INTERVAL = 12000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_INTERVAL > 1) ? $clog2(TICK_INTERVAL) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = en && (cnt_reg == CW'(TICK_INTERVAL - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else if (en) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/fade_channels.sv
// Multi-channel triangular fade sequencer with phase-offset channels.
// Define FADE_CHANNELS_PWM_OUT_EN to add the pwm_out port and its shared PWM counter.
module fade_channels
    import fade_pkg::*;
#(
    parameter int NUM_CH        = 3,
    parameter int TICK_INTERVAL = 12000,
    parameter int STEPS         = 166,
    parameter int PWM_INTERVAL  = 1200,
    parameter int PHASE_OFS     = 2
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     en,
    input  logic                                     restart,
    output logic [NUM_CH*$clog2(PWM_INTERVAL+1)-1:0] pwm_value,
    output logic [NUM_CH*3-1:0]                      phase_state,
    output logic                                     cycle_done
`ifdef FADE_CHANNELS_PWM_OUT_EN
    ,
    output logic [NUM_CH-1:0]                        pwm_out
`endif
);

    localparam int STEP_VAL = PWM_INTERVAL / STEPS;
    localparam int W        = $clog2(PWM_INTERVAL + 1);
    localparam int SW       = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [W-1:0] MAX_W  = W'(PWM_INTERVAL);
    localparam logic [W:0]   MAX_W1 = (W + 1)'(PWM_INTERVAL);
    localparam logic [W:0]   STEP_W1 = (W + 1)'(STEP_VAL);

    logic          tick;
    logic          tick_run;
    logic          last_step;
    logic          advance;
    logic [SW-1:0] step_reg;
    logic          cycle_done_reg;
    state_t        ch0_state;

    fade_tick #(
        .TICK_INTERVAL(TICK_INTERVAL)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .clr  (restart),
        .tick (tick)
    );

    // restart wins over a tick landing on the same edge
    assign tick_run  = tick && !restart;
    assign last_step = (step_reg == SW'(STEPS - 1));
    assign advance   = tick_run && last_step;

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            step_reg <= '0;
        end else if (tick_run) begin
            step_reg <= last_step ? '0 : step_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        localparam state_t       RST_STATE = reset_state(gi, PHASE_OFS);
        localparam logic [W-1:0] RST_VALUE = W'(init_value(RST_STATE, PWM_INTERVAL));

        state_t       state_reg, state_next;
        logic [W-1:0] value_reg, value_next;
        logic [W:0]   sum, diff;
        logic         legal;

        always_comb begin
            state_next = state_reg;
            value_next = value_reg;
            sum        = {1'b0, value_reg} + STEP_W1;
            diff       = {1'b0, value_reg} - STEP_W1;
            legal      = (state_reg <= ST_LO2);
            if (tick_run) begin
                if (!legal) begin
                    state_next = ST_INC;
                    value_next = '0;
                end else if (advance) begin
                    state_next = next_state(state_reg);
                    if (state_next == ST_HI) begin
                        value_next = MAX_W;
                    end else if (state_next == ST_LO) begin
                        value_next = '0;
                    end
                end else if (state_reg == ST_INC) begin
                    value_next = (sum > MAX_W1) ? MAX_W : sum[W-1:0];
                end else if (state_reg == ST_DEC) begin
                    // borrow out of the extra bit means we went below zero
                    value_next = diff[W] ? '0 : diff[W-1:0];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n || restart) begin
                state_reg <= RST_STATE;
                value_reg <= RST_VALUE;
            end else begin
                state_reg <= state_next;
                value_reg <= value_next;
            end
        end

        assign pwm_value[gi*W +: W]  = value_reg;
        assign phase_state[gi*3 +: 3] = state_reg;

        if (gi == 0) begin : g_first
            assign ch0_state = state_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || restart) begin
            cycle_done_reg <= 1'b0;
        end else begin
            cycle_done_reg <= advance && (ch0_state == ST_LO2);
        end
    end

    assign cycle_done = cycle_done_reg;

`ifdef FADE_CHANNELS_PWM_OUT_EN
    localparam int PW = (PWM_INTERVAL > 1) ? $clog2(PWM_INTERVAL) : 1;

    logic [PW-1:0] pwm_cnt_reg;

    // free-running carrier: keeps toggling even while the fade is frozen
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pwm_cnt_reg <= '0;
        end else if (pwm_cnt_reg == PW'(PWM_INTERVAL - 1)) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
        end
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pwm
        logic pwm_out_reg;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pwm_out_reg <= 1'b0;
            end else begin
                pwm_out_reg <= (W'(pwm_cnt_reg) < pwm_value[gi*W +: W]);
            end
        end

        assign pwm_out[gi] = pwm_out_reg;
    end
`endif

endmodule

// File: tb/tb_fade_channels.sv
// Scoreboard bench for fade_channels with small parameters (4-cycle tick, 4 steps, MAX 16).
module tb_fade_channels;

    localparam int NUM_CH = 3;
    localparam int W      = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  en = 1'b0;
    logic                  restart = 1'b0;
    logic [NUM_CH*W-1:0]   pwm_value;
    logic [NUM_CH*3-1:0]   phase_state;
    logic                  cycle_done;
`ifdef FADE_CHANNELS_PWM_OUT_EN
    logic [NUM_CH-1:0]     pwm_out;
`endif

    fade_channels #(
        .NUM_CH       (NUM_CH),
        .TICK_INTERVAL(4),
        .STEPS        (4),
        .PWM_INTERVAL (16),
        .PHASE_OFS    (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .restart    (restart),
        .pwm_value  (pwm_value),
        .phase_state(phase_state),
        .cycle_done (cycle_done)
`ifdef FADE_CHANNELS_PWM_OUT_EN
        ,
        .pwm_out    (pwm_out)
`endif
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    typedef struct {
        int                  cyc;
        logic [NUM_CH*W-1:0] pv;
        logic [NUM_CH*3-1:0] ps;
        logic                cd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   base = 0;
    int   cd_cycles = 0;

    task automatic expect_at(input int d, input int v0, input int v1, input int v2,
                             input int s0, input int s1, input int s2, input logic cd);
        exp_t e;
        e.cyc = base + d;
        e.pv  = {5'(v2), 5'(v1), 5'(v0)};
        e.ps  = {3'(s2), 3'(s1), 3'(s0)};
        e.cd  = cd;
        exp_q.push_back(e);
    endtask

    task automatic wait_until(input int d);
        while (cyc_cnt < base + d) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (cycle_done === 1'b1) cd_cycles++;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            e = exp_q.pop_front();
            checks++;
            if (e.cyc != cyc_cnt || pwm_value !== e.pv || phase_state !== e.ps || cycle_done !== e.cd) begin
                errors++;
                $display("FAIL outputs@cyc%0d (rel %0d): pwm_value=%h phase_state=%h cycle_done=%b, required %h %h %b",
                         cyc_cnt, e.cyc - base, pwm_value, phase_state, cycle_done, e.pv, e.ps, e.cd);
            end else begin
                $display("ok   outputs@cyc%0d (rel %0d): pwm_value=%h phase_state=%h cycle_done=%b",
                         cyc_cnt, e.cyc - base, pwm_value, phase_state, cycle_done);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
`ifdef FADE_CHANNELS_PWM_OUT_EN
        int hi0, hi1, hi2;
`endif
        // reset held with en/restart active to show reset dominates
        en      = 1'b1;
        restart = 1'b1;
        repeat (3) @(negedge clk);
        base = cyc_cnt;
        expect_at(2, 0, 16, 0, 0, 2, 4, 1'b0);
        repeat (3) @(negedge clk);
        restart = 1'b0;

        base  = cyc_cnt;
        rst_n = 1'b1;
        en    = 1'b1;
        // ramp and phase walk over one full 24-tick cycle
        expect_at(3,    0, 16,  0,  0, 2, 4, 1'b0);
        expect_at(4,    4, 16,  0,  0, 2, 4, 1'b0);
        expect_at(8,    8, 16,  0,  0, 2, 4, 1'b0);
        expect_at(12,  12, 16,  0,  0, 2, 4, 1'b0);
        expect_at(15,  12, 16,  0,  0, 2, 4, 1'b0);
        expect_at(16,  16, 16,  0,  1, 3, 5, 1'b0);
        expect_at(20,  16, 12,  0,  1, 3, 5, 1'b0);
        expect_at(28,  16,  4,  0,  1, 3, 5, 1'b0);
        expect_at(32,  16,  0,  0,  2, 4, 0, 1'b0);
        expect_at(48,  16,  0, 16,  3, 5, 1, 1'b0);
        expect_at(64,   0,  0, 16,  4, 0, 2, 1'b0);
        expect_at(80,   0, 16, 16,  5, 1, 3, 1'b0);
        expect_at(92,   0, 16,  4,  5, 1, 3, 1'b0);
        expect_at(96,   0, 16,  0,  0, 2, 4, 1'b1);
        expect_at(97,   0, 16,  0,  0, 2, 4, 1'b0);
        // freeze for 10 cycles mid-ramp
        expect_at(100,  4, 16,  0,  0, 2, 4, 1'b0);
        expect_at(104,  8, 16,  0,  0, 2, 4, 1'b0);
        expect_at(110,  8, 16,  0,  0, 2, 4, 1'b0);
        expect_at(117,  8, 16,  0,  0, 2, 4, 1'b0);
        expect_at(118, 12, 16,  0,  0, 2, 4, 1'b0);
        // restart on a transition tick
        expect_at(121, 12, 16,  0,  0, 2, 4, 1'b0);
        expect_at(122,  0, 16,  0,  0, 2, 4, 1'b0);
        expect_at(125,  0, 16,  0,  0, 2, 4, 1'b0);
        expect_at(126,  4, 16,  0,  0, 2, 4, 1'b0);
        // reset landing on a tick while ch1 is ramping down
        expect_at(138, 16, 16,  0,  1, 3, 5, 1'b0);
        expect_at(146, 16,  8,  0,  1, 3, 5, 1'b0);
        expect_at(149, 16,  8,  0,  1, 3, 5, 1'b0);
        expect_at(150,  0, 16,  0,  0, 2, 4, 1'b0);
        expect_at(155,  0, 16,  0,  0, 2, 4, 1'b0);
        expect_at(156,  4, 16,  0,  0, 2, 4, 1'b0);
        expect_at(164, 12, 16,  0,  0, 2, 4, 1'b0);
        expect_at(197, 12, 16,  0,  0, 2, 4, 1'b0);

        wait_until(105); en = 1'b0;
        wait_until(115); en = 1'b1;
        wait_until(121); restart = 1'b1;
        wait_until(122); restart = 1'b0;
        wait_until(149); rst_n = 1'b0;
        wait_until(152); rst_n = 1'b1;
        wait_until(165); en = 1'b0;

`ifdef FADE_CHANNELS_PWM_OUT_EN
        wait_until(170);
        hi0 = 0; hi1 = 0; hi2 = 0;
        for (int i = 0; i < 32; i++) begin
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
            @(negedge clk);
        end
        checks++;
        if (hi0 != 24) begin errors++; $display("FAIL pwm_out0 duty: %0d high of 32, required 24", hi0); end
        else $display("ok   pwm_out0 duty: %0d high of 32", hi0);
        checks++;
        if (hi1 != 32) begin errors++; $display("FAIL pwm_out1 duty: %0d high of 32, required 32", hi1); end
        else $display("ok   pwm_out1 duty: %0d high of 32", hi1);
        checks++;
        if (hi2 != 0) begin errors++; $display("FAIL pwm_out2 duty: %0d high of 32, required 0", hi2); end
        else $display("ok   pwm_out2 duty: %0d high of 32", hi2);
`endif
        wait_until(202);

        checks++;
        if (cd_cycles != 1) begin errors++; $display("FAIL cycle_done pulses: %0d high cycles, required 1", cd_cycles); end
        else $display("ok   cycle_done pulses: %0d", cd_cycles);
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard drain: %0d entries left, required 0", exp_q.size()); end
        else $display("ok   scoreboard drained");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
